bcd_to_excess3_serial: RTL and testbench

Streaming converter from packed multi-digit BCD to packed Excess-3. It is the encode-direction companion to the team's Excess-3-to-BCD decoder.
- Accepts one packed word per valid/ready handshake.
- Converts one digit per clock, least-significant digit first.
- Presents the result word with an error flag and the index of the first illegal BCD digit.
- Sits between a BCD source (counter or display path) and Excess-3 arithmetic or display logic.

---
 rtl/bcd_to_excess3_serial.sv | 121 ++++++++++++
 tb/tb_bcd_to_excess3_serial.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_excess3_serial.sv
// bcd_to_excess3_serial: streaming packed-BCD to packed-Excess-3 encoder.
// Accepts one word per handshake, converts one digit per clock (LSD first),
// then presents the result with an error flag and the first illegal digit index.
module bcd_to_excess3_serial #(
  parameter  int unsigned DIGITS = 4,
  localparam int unsigned IDXW   = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_xs3,
  output logic                  out_err,
  output logic [IDXW-1:0]       out_err_idx,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   sr_q, sr_d;
  logic [IDXW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   xs3_q, xs3_d;
  logic                  err_q, err_d;
  logic [IDXW-1:0]       idx_q, idx_d;

  logic [3:0]            dig;
  logic                  dig_bad;
  logic [3:0]            dig_xs3;

  // Per-digit mapping of the digit currently at the bottom of the shift register.
  always_comb begin
    dig     = sr_q[3:0];
    dig_bad = (dig > 4'd9);
    dig_xs3 = dig_bad ? 4'd0 : (dig + 4'd3);
  end

  // State register and datapath registers; rst clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      xs3_q   <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      xs3_q   <= xs3_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and datapath update; every register holds unless its state acts on it.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    xs3_d   = xs3_q;
    err_d   = err_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = in_bcd;
          cnt_d   = '0;
          xs3_d   = '0;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        sr_d  = sr_q >> 4;
        cnt_d = cnt_q + 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
          if (cnt_q == IDXW'(k)) begin
            xs3_d[4*k +: 4] = dig_xs3;
          end
        end
        // Only the first illegal digit is recorded.
        if (dig_bad && !err_q) begin
          err_d = 1'b1;
          idx_d = cnt_q;
        end
        if (cnt_q == IDXW'(DIGITS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake flags decode directly from the state.
  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    busy        = (state_q != IDLE);
    out_xs3     = xs3_q;
    out_err     = err_q;
    out_err_idx = idx_q;
  end

endmodule

// File: tb/tb_bcd_to_excess3_serial.sv
// Directed testbench for bcd_to_excess3_serial (DIGITS=4).
module tb_bcd_to_excess3_serial;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned IDXW   = 2;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic [4*DIGITS-1:0] in_bcd;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic [4*DIGITS-1:0] out_xs3;
  logic                out_err;
  logic [IDXW-1:0]     out_err_idx;
  logic                busy;

  int n_assert;
  int n_fail;

  bcd_to_excess3_serial #(.DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bcd      (in_bcd),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_xs3     (out_xs3),
    .out_err     (out_err),
    .out_err_idx (out_err_idx),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a word, check latency and result, then drain it with out_ready.
  task automatic send_word(input logic [15:0] bcd, input logic [15:0] exp_xs3,
                           input logic exp_err, input logic [1:0] exp_idx,
                           input string tag);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    check({tag, "_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_bcd   = bcd;
    step();
    in_valid = 1'b0;
    in_bcd   = 16'h0;
    check({tag, "_err_clr"}, out_err, 1'b0);
    k = 0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    check({tag, "_lat"}, k, 4);
    check({tag, "_xs3"}, out_xs3, exp_xs3);
    check({tag, "_err"}, out_err, exp_err);
    check({tag, "_idx"}, out_err_idx, exp_idx);
    check({tag, "_inrdy_lo"}, in_ready, 1'b0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_ov_fall"}, out_valid, 1'b0);
    check({tag, "_ir_rise"}, in_ready, 1'b1);
    check({tag, "_hold_xs3"}, out_xs3, exp_xs3);
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] e;
    logic [15:0] snap;
    int          acc_cyc [$];
    int          cyc;

    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bcd    = 16'h0;
    out_ready = 1'b0;
    #12;
    // 1. reset state
    check("rst_in_ready",  in_ready,    1'b1);
    check("rst_out_valid", out_valid,   1'b0);
    check("rst_busy",      busy,        1'b0);
    check("rst_xs3",       out_xs3,     16'h0);
    check("rst_err",       out_err,     1'b0);
    check("rst_idx",       out_err_idx, 2'd0);
    rst = 1'b0;
    step();

    send_word(16'h1234, 16'h4567, 1'b0, 2'd0, "w1234");

    // 2. legal digit sweep
    send_word(16'h9090, 16'hC3C3, 1'b0, 2'd0, "w9090");
    send_word(16'h0000, 16'h3333, 1'b0, 2'd0, "w0000");
    for (int d = 0; d < 10; d++) begin
      w = {4{4'(d)}};
      e = {4{4'(d + 3)}};
      send_word(w, e, 1'b0, 2'd0, $sformatf("sweep%0d", d));
    end
    send_word(16'h0987, 16'h3CBA, 1'b0, 2'd0, "w0987");

    // 3. illegal digits
    send_word(16'h12A4, 16'h4507, 1'b1, 2'd1, "w12A4");
    send_word(16'hFB00, 16'h0033, 1'b1, 2'd2, "wFB00");
    send_word(16'hA999, 16'h0CCC, 1'b1, 2'd3, "wA999");

    // 4. backpressure in DONE
    in_valid = 1'b1;
    in_bcd   = 16'h4321;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("bp_valid", out_valid, 1'b1);
    check("bp_xs3_first", out_xs3, 16'h7654);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_bcd   = 16'(i * 16'h1111);
      step();
      check("bp_hold_valid", out_valid,   1'b1);
      check("bp_hold_xs3",   out_xs3,     16'h7654);
      check("bp_hold_err",   out_err,     1'b0);
      check("bp_hold_idx",   out_err_idx, 2'd0);
      check("bp_in_ready",   in_ready,    1'b0);
      check("bp_busy",       busy,        1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release_ov", out_valid, 1'b0);
    check("bp_release_ir", in_ready,  1'b1);
    check("bp_release_busy", busy,    1'b0);

    // back-to-back with in_valid and out_ready held high
    in_valid  = 1'b1;
    in_bcd    = 16'h2468;
    out_ready = 1'b1;
    cyc       = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready && in_valid) acc_cyc.push_back(cyc);
      step();
      cyc++;
      if (out_valid) begin
        check("b2b_xs3", out_xs3, 16'h579B);
        check("b2b_no_overlap", in_ready, 1'b0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_count_ge3", (acc_cyc.size() >= 3), 1'b1);
    if (acc_cyc.size() >= 3) begin
      check("b2b_gap1", acc_cyc[1] - acc_cyc[0], 6);
      check("b2b_gap2", acc_cyc[2] - acc_cyc[1], 6);
    end
    for (int i = 0; i < 8 && !in_ready; i++) begin
      out_ready = out_valid;
      step();
    end
    out_ready = 1'b0;
    check("b2b_drained", in_ready, 1'b1);

    // 5. asynchronous reset two edges into CONV
    in_valid = 1'b1;
    in_bcd   = 16'h1234;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("ar_partial", out_xs3, 16'h0067);
    #2;
    rst = 1'b1;
    #1;
    check("ar_xs3",   out_xs3,   16'h0);
    check("ar_busy",  busy,      1'b0);
    check("ar_ready", in_ready,  1'b1);
    check("ar_valid", out_valid, 1'b0);
    #3;
    rst = 1'b0;
    step();
    send_word(16'h5678, 16'h89AB, 1'b0, 2'd0, "w5678");

    // reset while in DONE
    in_valid = 1'b1;
    in_bcd   = 16'hB000;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("rd_valid", out_valid, 1'b1);
    check("rd_err",   out_err,   1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rd_cleared_valid", out_valid, 1'b0);
    check("rd_cleared_err",   out_err,   1'b0);
    check("rd_cleared_idx",   out_err_idx, 2'd0);
    #3;
    rst = 1'b0;
    step();

    // 6. error cleared at next accept
    send_word(16'hFFFF, 16'h0000, 1'b1, 2'd0, "wFFFF");
    send_word(16'h0001, 16'h3334, 1'b0, 2'd0, "w0001");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
